clock_divide_multi: RTL and testbench

- Parametrised multi-channel successor to the single-output 100 MHz -> 100 Hz divider.
- Produces NUM_CH independent divided clocks from clk_100mhz. Each channel has a runtime-programmable divisor, an enable, a registered near-50% duty clock output and a one-cycle tick strobe.
- Sits at top level and feeds display refresh, debounce and timer logic.
- Divisor changes are glitch-free, and all channels can be phase-aligned with a single restart strobe.

---
 rtl/clock_divide_multi.sv | 110 +++++++++++
 tb/tb_clock_divide_multi.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divide_multi.sv
// Multi-channel programmable clock divider.
// Each channel derives a registered, near-50% duty clock and a one-cycle tick
// from clk_100mhz. Divisor updates on a running channel are held in a shadow
// register and only take effect at the end of the current period, so no runt
// pulses appear on clk_out. A single sync_restart strobe re-phases every
// channel to the same edge.
module clock_divide_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 27,
  parameter int RESET_DIV = 1_000_000
) (
  input  logic                                         clk_100mhz,
  input  logic                                         rst_n,
  input  logic [NUM_CH-1:0]                            en,
  input  logic                                         div_load,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_ch,
  input  logic [CNT_W-1:0]                             div_val,
  input  logic                                         sync_restart,
  output logic                                         load_err,
  output logic [NUM_CH-1:0]                            tick,
  output logic [NUM_CH-1:0]                            clk_out
);

  localparam int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic ch_ok;
  logic load_ok;

  // When NUM_CH fills the select field every code is a real channel, so the
  // range compare is dropped rather than left as an always-true comparison.
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (32'(div_ch) < NUM_CH);
  end

  assign load_ok = div_load && ch_ok && (div_val != '0);

  // Rejected load reported for exactly one cycle after the strobe.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= div_load && !load_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] nxt;
    logic [CNT_W:0]   half;
    logic             pend;
    logic             wrap;
    logic             ld;
    logic             tick_q;
    logic             clk_q;

    assign ld   = load_ok && (div_ch == CH_W'(i));
    assign wrap = (cnt == (div - ONE));
    assign nxt  = wrap ? '0 : (cnt + ONE);
    // One extra bit keeps div+1 from wrapping at the largest divisor.
    assign half = ({1'b0, div} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    // Period counter, divisor/shadow bookkeeping and registered outputs.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        div    <= RST_DIV;
        shadow <= RST_DIV;
        pend   <= 1'b0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else if (sync_restart || !en[i]) begin
        // No period is in flight here, so a new divisor (fresh or pending)
        // can be committed straight away.
        cnt    <= '0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
        pend   <= 1'b0;
        if (ld) begin
          div <= div_val;
        end else if (pend) begin
          div <= shadow;
        end
      end else begin
        cnt    <= nxt;
        tick_q <= wrap;
        clk_q  <= ({1'b0, nxt} < half);
        if (wrap && pend) begin
          div  <= shadow;
          pend <= 1'b0;
        end
        // A load landing on the wrap edge goes to shadow and waits for the
        // following wrap; later loads simply overwrite the shadow.
        if (ld) begin
          shadow <= div_val;
          pend   <= 1'b1;
        end
      end
    end

    assign tick[i]    = tick_q;
    assign clk_out[i] = clk_q;
  end

endmodule

// File: tb/tb_clock_divide_multi.sv
// Testbench for clock_divide_multi: directed scenarios plus a randomized run,
// compared cycle by cycle against a period-position model of each channel.
module tb_clock_divide_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int RDIV = 10;

  logic            clk_100mhz = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  en;
  logic            div_load;
  logic [1:0]      div_ch;
  logic [CW-1:0]   div_val;
  logic            sync_restart;
  logic            load_err;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  clk_out;

  // Second instance with a channel count that leaves unused select codes.
  logic [2:0]      en_b;
  logic            div_load_b;
  logic [1:0]      div_ch_b;
  logic [CW-1:0]   div_val_b;
  logic            sync_restart_b;
  logic            load_err_b;
  logic [2:0]      tick_b;
  logic [2:0]      clk_out_b;

  int checks = 0;
  int errors = 0;

  // Reference state: position inside the current period, live divisor,
  // pending divisor.
  int   m_pos [NCH];
  int   m_div [NCH];
  int   m_sh  [NCH];
  bit   m_pend[NCH];
  logic [NCH-1:0] e_tick;
  logic [NCH-1:0] e_clk;
  logic           e_err;

  clock_divide_multi #(.NUM_CH(NCH), .CNT_W(CW), .RESET_DIV(RDIV)) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .en          (en),
    .div_load    (div_load),
    .div_ch      (div_ch),
    .div_val     (div_val),
    .sync_restart(sync_restart),
    .load_err    (load_err),
    .tick        (tick),
    .clk_out     (clk_out)
  );

  clock_divide_multi #(.NUM_CH(3), .CNT_W(CW), .RESET_DIV(6)) dut_b (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .en          (en_b),
    .div_load    (div_load_b),
    .div_ch      (div_ch_b),
    .div_val     (div_val_b),
    .sync_restart(sync_restart_b),
    .load_err    (load_err_b),
    .tick        (tick_b),
    .clk_out     (clk_out_b)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_pos[i]  = 0;
      m_div[i]  = RDIV;
      m_sh[i]   = RDIV;
      m_pend[i] = 1'b0;
    end
    e_tick = '0;
    e_clk  = '0;
    e_err  = 1'b0;
  endtask

  // One clock edge of the behavioural rules: a running channel advances one
  // position; reaching div positions completes a period (tick, adopt pending
  // divisor); clk_out is high for the first ceil(div/2) positions of a period.
  task automatic model_step();
    bit ok;
    bit ld;
    int half;
    ok    = div_load && (div_val != 0);
    e_err = div_load && !ok;
    for (int i = 0; i < NCH; i++) begin
      ld = ok && (div_ch == i);
      if (sync_restart || !en[i]) begin
        m_pos[i]  = 0;
        e_tick[i] = 1'b0;
        e_clk[i]  = 1'b0;
        if (ld) m_div[i] = div_val;
        else if (m_pend[i]) m_div[i] = m_sh[i];
        m_pend[i] = 1'b0;
      end else begin
        half      = (m_div[i] + 1) / 2;
        m_pos[i]  = m_pos[i] + 1;
        e_tick[i] = 1'b0;
        if (m_pos[i] == m_div[i]) begin
          m_pos[i]  = 0;
          e_tick[i] = 1'b1;
          if (m_pend[i]) begin
            m_div[i]  = m_sh[i];
            m_pend[i] = 1'b0;
          end
        end
        e_clk[i] = (m_pos[i] < half);
        if (ld) begin
          m_sh[i]   = div_val;
          m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_100mhz);
    model_step();
    #1;
    chk({tag, " tick"}, tick, e_tick);
    chk({tag, " clk_out"}, clk_out, e_clk);
    chk({tag, " load_err"}, load_err, e_err);
    div_load     = 1'b0;
    sync_restart = 1'b0;
    div_load_b   = 1'b0;
  endtask

  initial begin
    logic [11:0] cv;
    logic [11:0] tv;
    int n;
    int pulses;
    int err_at;
    int highs;
    int ticks;
    int ticks2;
    int r;
    int q;

    rst_n = 1'b0; en = '0; div_load = 1'b0; div_ch = '0; div_val = '0; sync_restart = 1'b0;
    en_b = '0; div_load_b = 1'b0; div_ch_b = '0; div_val_b = '0; sync_restart_b = 1'b0;
    model_reset();
    #12;
    chk("reset tick", tick, 0);
    chk("reset clk_out", clk_out, 0);
    chk("reset load_err", load_err, 0);
    chk("reset b outputs", {load_err_b, tick_b, clk_out_b}, 0);
    @(negedge clk_100mhz);
    rst_n = 1'b1;

    // Divisor 4 on channel 0 loaded while disabled, then enabled.
    div_load = 1'b1; div_ch = 2'd0; div_val = 8'd4;
    cycle("t1 load");
    en = 4'b0001; cv = '0; tv = '0;
    for (int k = 0; k < 12; k++) begin
      cycle("t1 run");
      cv[k] = clk_out[0];
      tv[k] = tick[0];
    end
    chk("t1 clk pattern", cv, 12'h999);
    chk("t1 tick pattern", tv, 12'h888);

    // Channel 1 divisor 5, reloaded to 3 when its count is at 2.
    div_load = 1'b1; div_ch = 2'd1; div_val = 8'd5;
    cycle("t2 load");
    en = 4'b0011; tv = '0;
    cycle("t2 run"); tv[0] = tick[1];
    cycle("t2 run"); tv[1] = tick[1];
    div_load = 1'b1; div_ch = 2'd1; div_val = 8'd3;
    for (int k = 2; k < 12; k++) begin
      cycle("t2 run");
      tv[k] = tick[1];
    end
    chk("t2 tick pattern", tv, 12'h490);

    // Divisors 2..5 on all channels, then a common restart.
    en = '0;
    cycle("t3 stop");
    for (int c = 0; c < 4; c++) begin
      div_load = 1'b1; div_ch = 2'(c); div_val = 8'(c + 2);
      cycle("t3 load");
    end
    en = 4'hF;
    repeat (7) cycle("t3 run");
    sync_restart = 1'b1;
    cycle("t3 restart");
    chk("t3 clk_out after restart", clk_out, 0);
    n = 0;
    for (int k = 0; k < 120; k++) begin
      cycle("t3 aligned");
      if (tick == 4'hF) n++;
    end
    chk("t3 coincident ticks", n, 2);

    // Rejected loads.
    div_load = 1'b1; div_ch = 2'd1; div_val = 8'd0;
    cycle("t4 zero");
    chk("t4 load_err zero div", load_err, 1);
    cycle("t4 after");
    chk("t4 load_err single", load_err, 0);
    en_b = 3'b001; n = 0; pulses = 0; err_at = -1;
    for (int k = 0; k < 18; k++) begin
      if (k == 5) begin
        div_load_b = 1'b1; div_ch_b = 2'd3; div_val_b = 8'd2;
      end
      cycle("t4 b");
      if (tick_b[0]) n++;
      if (load_err_b) begin
        pulses++;
        err_at = k;
      end
    end
    chk("t4b ticks unchanged div", n, 3);
    chk("t4b load_err pulses", pulses, 1);
    chk("t4b load_err cycle", err_at, 5);
    en_b = '0;

    // Async reset mid-period with divisor 7 on channel 2.
    en = '0;
    cycle("t6 stop");
    div_load = 1'b1; div_ch = 2'd2; div_val = 8'd7;
    cycle("t6 load");
    en = 4'b0100;
    repeat (14) cycle("t6 run");
    #2 rst_n = 1'b0;
    #1;
    chk("t6 tick async", tick, 0);
    chk("t6 clk_out async", clk_out, 0);
    model_reset();
    @(negedge clk_100mhz);
    rst_n = 1'b1;

    // Reset divisor on channels 0 and 2: 2*RDIV cycles -> 2 ticks, half high.
    en = 4'b0101; ticks = 0; ticks2 = 0; highs = 0;
    for (int k = 0; k < 2 * RDIV; k++) begin
      cycle("t5 run");
      ticks  += int'(tick[0]);
      ticks2 += int'(tick[2]);
      highs  += int'(clk_out[0]);
    end
    chk("t5 ticks ch0", ticks, 2);
    chk("t5 ticks ch2", ticks2, 2);
    chk("t5 high ch0", highs, RDIV);

    // Largest divisor: duty must not overflow.
    en = '0;
    cycle("t8 stop");
    div_load = 1'b1; div_ch = 2'd3; div_val = 8'd255;
    cycle("t8 load");
    en = 4'b1000; ticks = 0; highs = 0;
    for (int k = 0; k < 255; k++) begin
      cycle("t8 run");
      ticks += int'(tick[3]);
      highs += int'(clk_out[3]);
    end
    chk("t8 ticks", ticks, 1);
    chk("t8 high", highs, 128);

    // Randomized traffic.
    en = 4'hF;
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 99);
      if (r < 4) en = 4'($urandom);
      if (r >= 10 && r < 25) begin
        div_load = 1'b1;
        div_ch   = 2'($urandom);
        q = $urandom_range(0, 19);
        if (q == 0) div_val = 8'd0;
        else if (q == 1) div_val = 8'd255;
        else div_val = 8'($urandom_range(1, 9));
      end
      if ($urandom_range(0, 49) == 0) sync_restart = 1'b1;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
